// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: function codes, flag bundle, masks.
// The DATA_N define sets the default datapath width.
`ifndef DATA_N
`define DATA_N 8
`endif

package alu_pipe_pkg;

    localparam int ALU_DATA_N = `DATA_N;

    typedef enum logic [3:0] {
        ALU_TXA = 4'd0,
        ALU_TXB = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3,
        ALU_ASL = 4'd4,
        ALU_LSR = 4'd5,
        ALU_ROL = 4'd6,
        ALU_ROR = 4'd7,
        ALU_AND = 4'd8,
        ALU_ORA = 4'd9,
        ALU_EOR = 4'd10
    } alu_func_t;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
        logic c;
    } flag_t;

    localparam logic [3:0] FLAG_MASK_NONE = 4'b0000;
    localparam logic [3:0] FLAG_MASK_ALL  = 4'b1111;
    localparam logic [3:0] FLAG_MASK_NZC  = 4'b1011;
    localparam logic [3:0] FLAG_MASK_NZ   = 4'b1010;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU: result, N/V/Z/C flags, flag mask and
// per-nibble binary carries for the decimal adjust stage.
module alu_comb
    import alu_pipe_pkg::*;
#(
    parameter int DATA_N = ALU_DATA_N,
    parameter int FUNC_N = 4
) (
    input  logic [FUNC_N-1:0]   func,
    input  logic [DATA_N-1:0]   a,
    input  logic [DATA_N-1:0]   b,
    input  logic                cin,
    output logic [DATA_N-1:0]   r,
    output flag_t               flags,
    output logic [3:0]          mask,
    output logic [DATA_N/4-1:0] nib_c
);

    localparam int MSB = DATA_N - 1;
    localparam int NIB = DATA_N / 4;

    logic              is_sub;
    logic [DATA_N-1:0] bx;
    logic [DATA_N:0]   sum;
    logic              c;
    logic              v;
    logic              known;

    assign is_sub = (func == FUNC_N'(ALU_SUB));
    assign bx     = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, bx} + {{DATA_N{1'b0}}, cin};

    // Carry out of each nibble, recovered from the full-width sum.
    always_comb begin
        nib_c = '0;
        for (int i = 0; i < NIB - 1; i++) begin
            nib_c[i] = a[4*i+4] ^ bx[4*i+4] ^ sum[4*i+4];
        end
        nib_c[NIB-1] = sum[DATA_N];
    end

    always_comb begin
        r     = '0;
        c     = 1'b0;
        v     = 1'b0;
        known = 1'b1;
        mask  = FLAG_MASK_NONE;
        unique case (func)
            FUNC_N'(ALU_ADD), FUNC_N'(ALU_SUB): begin
                r    = sum[MSB:0];
                c    = sum[DATA_N];
                v    = (a[MSB] ^ r[MSB]) & (bx[MSB] ^ r[MSB]);
                mask = FLAG_MASK_ALL;
            end
            FUNC_N'(ALU_ASL): begin
                r    = {a[MSB-1:0], 1'b0};
                c    = a[MSB];
                mask = FLAG_MASK_NZC;
            end
            FUNC_N'(ALU_LSR): begin
                r    = {1'b0, a[MSB:1]};
                c    = a[0];
                mask = FLAG_MASK_NZC;
            end
            FUNC_N'(ALU_ROL): begin
                r    = {a[MSB-1:0], cin};
                c    = a[MSB];
                mask = FLAG_MASK_NZC;
            end
            FUNC_N'(ALU_ROR): begin
                r    = {cin, a[MSB:1]};
                c    = a[0];
                mask = FLAG_MASK_NZC;
            end
            FUNC_N'(ALU_TXA): begin
                r    = a;
                c    = cin;
                mask = FLAG_MASK_NZ;
            end
            FUNC_N'(ALU_TXB): begin
                r    = b;
                c    = cin;
                mask = FLAG_MASK_NZ;
            end
            FUNC_N'(ALU_AND): begin
                r    = a & b;
                c    = cin;
                mask = FLAG_MASK_NZ;
            end
            FUNC_N'(ALU_ORA): begin
                r    = a | b;
                c    = cin;
                mask = FLAG_MASK_NZ;
            end
            FUNC_N'(ALU_EOR): begin
                r    = a ^ b;
                c    = cin;
                mask = FLAG_MASK_NZ;
            end
            default: begin
                known = 1'b0;
            end
        endcase
        flags.n = known & r[MSB];
        flags.v = known & v;
        flags.z = known & (r == '0);
        flags.c = known & c;
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered, valid/ready handshaked ALU with N/V/Z/C flags and mask.
// Define ALU_DECIMAL_EN to add the second-cycle 6502 BCD adjust.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int DATA_N = ALU_DATA_N,
    parameter int FUNC_N = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FUNC_N-1:0] func,
    input  logic [DATA_N-1:0] a,
    input  logic [DATA_N-1:0] b,
    input  logic              cin,
    input  logic              dec,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_N-1:0] result,
    output logic [3:0]        flags,
    output logic [3:0]        flag_mask
);

    localparam int NIB = DATA_N / 4;

`ifdef ALU_DECIMAL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FULL = 2'd1,
        ST_ADJ  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FULL = 2'd1
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_N-1:0] result_q, result_d;
    flag_t             flags_q, flags_d;
    logic [3:0]        mask_q, mask_d;

    logic [DATA_N-1:0] c_r;
    flag_t             c_flags;
    logic [3:0]        c_mask;
    logic [NIB-1:0]    c_nib;
    logic              accept;
    logic              pop;

    alu_comb #(
        .DATA_N (DATA_N),
        .FUNC_N (FUNC_N)
    ) u_comb (
        .func  (func),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .r     (c_r),
        .flags (c_flags),
        .mask  (c_mask),
        .nib_c (c_nib)
    );

    assign req_ready = ~reset & ((state_q == ST_IDLE) |
                                 ((state_q == ST_FULL) & res_ready));
    assign accept    = req_valid & req_ready;
    assign res_valid = (state_q == ST_FULL);
    assign pop       = res_valid & res_ready;
    assign result    = result_q;
    assign flags     = flags_q;
    assign flag_mask = mask_q;

`ifdef ALU_DECIMAL_EN
    logic [NIB-1:0]    nib_q, nib_d;
    logic              sub_q, sub_d;
    logic              dec_op;
    logic [DATA_N-1:0] adj_r;
    logic              adj_c;
    logic [4:0]        digit;
    logic              ripple;
    logic              dcarry;

    assign dec_op = dec & ((func == FUNC_N'(ALU_ADD)) |
                           (func == FUNC_N'(ALU_SUB)));

    // ripple carries the extra decimal carry that the binary sum lacked.
    always_comb begin
        adj_r  = result_q;
        ripple = 1'b0;
        dcarry = 1'b0;
        digit  = '0;
        for (int i = 0; i < NIB; i++) begin
            digit = {1'b0, result_q[4*i +: 4]} + {4'd0, ripple};
            if (sub_q) begin
                if (!nib_q[i]) begin
                    adj_r[4*i +: 4] = result_q[4*i +: 4] - 4'd6;
                end
                dcarry = nib_q[i];
            end else begin
                dcarry = nib_q[i] | (digit > 5'd9);
                adj_r[4*i +: 4] = digit[3:0] + (dcarry ? 4'd6 : 4'd0);
                ripple = ~nib_q[i] & (digit > 5'd9);
            end
        end
        adj_c = dcarry;
    end
`else
    logic unused_dec;
    assign unused_dec = ^{dec, c_nib};
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        mask_d   = mask_q;
`ifdef ALU_DECIMAL_EN
        nib_d    = nib_q;
        sub_d    = sub_q;
`endif
        if (accept) begin
            state_d  = ST_FULL;
            result_d = c_r;
            flags_d  = c_flags;
            mask_d   = c_mask;
`ifdef ALU_DECIMAL_EN
            if (dec_op) begin
                state_d = ST_ADJ;
                nib_d   = c_nib;
                sub_d   = (func == FUNC_N'(ALU_SUB));
            end
`endif
        end else if (pop) begin
            state_d = ST_IDLE;
        end
`ifdef ALU_DECIMAL_EN
        else if (state_q == ST_ADJ) begin
            state_d   = ST_FULL;
            result_d  = adj_r;
            flags_d.c = adj_c;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            mask_q   <= '0;
`ifdef ALU_DECIMAL_EN
            nib_q    <= '0;
            sub_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            mask_q   <= mask_d;
`ifdef ALU_DECIMAL_EN
            nib_q    <= nib_d;
            sub_q    <= sub_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: vector table, corner sequences,
// and random ops against an integer reference model.
module tb_alu_pipe;

    localparam int W = 8;
`ifdef ALU_DECIMAL_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   func;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         dec;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic [3:0]   flag_mask;

    always #5 clk = ~clk;

    alu_pipe #(.DATA_N(W), .FUNC_N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .func      (func),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .dec       (dec),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .flags     (flags),
        .flag_mask (flag_mask)
    );

    typedef struct {
        logic [3:0] f;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       dec;
        logic [7:0] r;
        logic [3:0] fl;
        logic [3:0] m;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] r;
        logic [3:0] fl;
        logic [3:0] m;
        int         lat;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] f, input logic [7:0] av,
                                input logic [7:0] bv, input logic ci,
                                input logic dc, input logic [7:0] r,
                                input logic [3:0] fl, input logic [3:0] m,
                                input int lat);
        vec_t v;
        v.f = f; v.a = av; v.b = bv; v.cin = ci; v.dec = dc;
        v.r = r; v.fl = fl; v.m = m; v.lat = lat;
        return v;
    endfunction

    function automatic logic [7:0] bcd();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    function automatic exp_t model(input logic [3:0] f, input logic [7:0] av,
                                   input logic [7:0] bv, input logic ci,
                                   input logic dc);
        exp_t e;
        int ai, bi, bb, s, r, c, v, lo, hi, k;
        bit known;
        ai = int'(av); bi = int'(bv);
        c = int'(ci); v = 0; r = 0; known = 1'b1;
        e.lat = 1;
        e.m = 4'b1010;
        case (f)
            4'd0: r = ai;
            4'd1: r = bi;
            4'd2, 4'd3: begin
                bb = (f == 4'd3) ? 255 - bi : bi;
                s = ai + bb + int'(ci);
                r = s % 256;
                c = s / 256;
                v = (((ai ^ r) & (bb ^ r)) >= 128) ? 1 : 0;
                e.m = 4'b1111;
            end
            4'd4: begin r = (ai * 2) % 256; c = ai / 128; e.m = 4'b1011; end
            4'd5: begin r = ai / 2; c = ai % 2; e.m = 4'b1011; end
            4'd6: begin
                r = (ai * 2) % 256 + int'(ci); c = ai / 128; e.m = 4'b1011;
            end
            4'd7: begin
                r = ai / 2 + int'(ci) * 128; c = ai % 2; e.m = 4'b1011;
            end
            4'd8: r = ai & bi;
            4'd9: r = ai | bi;
            4'd10: r = ai ^ bi;
            default: begin known = 1'b0; e.m = 4'b0000; end
        endcase
        e.r = r[7:0];
        e.fl = known ? {r >= 128, v[0], r == 0, c[0]} : 4'b0000;
        if (DEC_EN && dc && (f == 4'd2 || f == 4'd3)) begin
            e.lat = 2;
            if (f == 4'd2) begin
                k = int'(ci);
                lo = ai % 16 + bi % 16 + k;
                k = (lo > 9) ? 1 : 0;
                if (k == 1) lo = lo - 10;
                hi = ai / 16 + bi / 16 + k;
                k = (hi > 9) ? 1 : 0;
                if (k == 1) hi = hi - 10;
            end else begin
                k = 1 - int'(ci);
                lo = ai % 16 - bi % 16 - k;
                k = (lo < 0) ? 1 : 0;
                if (k == 1) lo = lo + 10;
                hi = ai / 16 - bi / 16 - k;
                k = (hi < 0) ? 1 : 0;
                if (k == 1) hi = hi + 10;
                k = 1 - k;
            end
            s = hi * 16 + lo;
            e.r = s[7:0];
            e.fl[0] = k[0];
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] f,
                          input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic dc, input exp_t e);
        int lat;
        @(negedge clk);
        func = f; a = av; b = bv; cin = ci; dec = dc;
        req_valid = 1'b1;
        res_ready = 1'b0;
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        if (e.lat == 2) begin
            check({tag, " adj req_ready"}, 32'(req_ready), 32'd0);
            check({tag, " adj res_valid"}, 32'(res_valid), 32'd0);
        end
        while (!res_valid && lat < 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " res_valid"}, 32'(res_valid), 32'd1);
        check({tag, " result"}, 32'(result), 32'(e.r));
        check({tag, " flags"}, 32'(flags), 32'(e.fl));
        check({tag, " mask"}, 32'(flag_mask), 32'(e.m));
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check({tag, " pop"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rf;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic       rd;
        logic [7:0] sexp[4];
        exp_t       e;

        reset = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
        func = '0; a = '0; b = '0; cin = 1'b0; dec = 1'b0;

        tbl.push_back(mk(4'd2, 8'h50, 8'h50, 0, 0, 8'hA0, 4'b1100, 4'hF, 1));
        tbl.push_back(mk(4'd3, 8'h00, 8'h01, 1, 0, 8'hFF, 4'b1000, 4'hF, 1));
        tbl.push_back(mk(4'd7, 8'h01, 8'h00, 1, 0, 8'h80, 4'b1001, 4'hB, 1));
        tbl.push_back(mk(4'd13, 8'h12, 8'h34, 1, 0, 8'h00, 4'b0000, 4'h0, 1));
        tbl.push_back(mk(4'd8, 8'hF0, 8'h0F, 1, 0, 8'h00, 4'b0011, 4'hA, 1));
        tbl.push_back(mk(4'd4, 8'h80, 8'h00, 0, 0, 8'h00, 4'b0011, 4'hB, 1));
        tbl.push_back(mk(4'd5, 8'h01, 8'h00, 0, 0, 8'h00, 4'b0011, 4'hB, 1));
        tbl.push_back(mk(4'd6, 8'h80, 8'h00, 1, 0, 8'h01, 4'b0001, 4'hB, 1));
        tbl.push_back(mk(4'd10, 8'hFF, 8'hFF, 0, 0, 8'h00, 4'b0010, 4'hA, 1));
        tbl.push_back(mk(4'd9, 8'h80, 8'h01, 0, 0, 8'h81, 4'b1000, 4'hA, 1));
        tbl.push_back(mk(4'd0, 8'h7F, 8'h00, 0, 0, 8'h7F, 4'b0000, 4'hA, 1));
        tbl.push_back(mk(4'd1, 8'h55, 8'h00, 1, 0, 8'h00, 4'b0011, 4'hA, 1));
        tbl.push_back(mk(4'd2, 8'h7F, 8'h01, 0, 0, 8'h80, 4'b1100, 4'hF, 1));
        tbl.push_back(mk(4'd2, 8'hFF, 8'h01, 0, 0, 8'h00, 4'b0011, 4'hF, 1));
        tbl.push_back(mk(4'd8, 8'hFF, 8'h0F, 0, 1, 8'h0F, 4'b0000, 4'hA, 1));
        tbl.push_back(mk(4'd2, 8'h19, 8'h28, 0, 1, DEC_EN ? 8'h47 : 8'h41,
                         4'b0000, 4'hF, DEC_EN ? 2 : 1));
        tbl.push_back(mk(4'd2, 8'h99, 8'h01, 0, 1, DEC_EN ? 8'h00 : 8'h9A,
                         DEC_EN ? 4'b1001 : 4'b1000, 4'hF, DEC_EN ? 2 : 1));
        tbl.push_back(mk(4'd3, 8'h50, 8'h01, 1, 1, DEC_EN ? 8'h49 : 8'h4F,
                         4'b0001, 4'hF, DEC_EN ? 2 : 1));

        repeat (2) @(posedge clk);
        #1;
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        check("reset mask", 32'(flag_mask), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle req_ready", 32'(req_ready), 32'd1);

        foreach (tbl[i]) begin
            e.r = tbl[i].r; e.fl = tbl[i].fl;
            e.m = tbl[i].m; e.lat = tbl[i].lat;
            run_op($sformatf("tbl%0d", i), tbl[i].f, tbl[i].a, tbl[i].b,
                   tbl[i].cin, tbl[i].dec, e);
        end

        // Back-to-back stream, then stall with res_ready low.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("stream%0d valid", i), 32'(res_valid), 32'd1);
                check($sformatf("stream%0d result", i), 32'(result),
                      32'(sexp[i-1]));
            end
            if (i < 4) begin
                func = 4'd8; a = 8'(8'h11 * (i + 1)); b = 8'h7E;
                cin = 1'b0; dec = 1'b0;
                sexp[i] = a & b;
                req_valid = 1'b1;
                res_ready = 1'b1;
                check($sformatf("stream%0d req_ready", i), 32'(req_ready),
                      32'd1);
            end else begin
                req_valid = 1'b0;
                res_ready = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            func = 4'd0; a = 8'hEE; req_valid = 1'b1;
            #1;
            check("stall req_ready", 32'(req_ready), 32'd0);
            check("stall valid", 32'(res_valid), 32'd1);
            check("stall result", 32'(result), 32'(sexp[3]));
            check("stall mask", 32'(flag_mask), 32'hA);
        end
        @(negedge clk);
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("stream drain", 32'(res_valid), 32'd0);

        // Asynchronous reset while holding 0x5A.
        @(negedge clk);
        func = 4'd0; a = 8'h5A; cin = 1'b0; dec = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("full before reset", 32'(result), 32'h5A);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async rst valid", 32'(res_valid), 32'd0);
        check("async rst result", 32'(result), 32'd0);
        check("async rst flags", 32'(flags), 32'd0);
        check("async rst mask", 32'(flag_mask), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post rst valid", 32'(res_valid), 32'd0);

`ifdef ALU_DECIMAL_EN
        @(negedge clk);
        func = 4'd2; a = 8'h19; b = 8'h28; cin = 1'b0; dec = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("adj pending valid", 32'(res_valid), 32'd0);
        reset = 1'b1;
        #1;
        check("adj rst result", 32'(result), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("adj rst valid", 32'(res_valid), 32'd0);
        check("adj rst result2", 32'(result), 32'd0);
`endif

        for (int n = 0; n < 200; n++) begin
            rf = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (DEC_EN && rd && (rf == 4'd2 || rf == 4'd3)) begin
                ra = bcd();
                rb = bcd();
            end else begin
                ra = 8'($urandom);
                rb = 8'($urandom);
            end
            e = model(rf, ra, rb, rc, rd);
            run_op($sformatf("rnd%0d f%0d a%0h b%0h", n, rf, ra, rb),
                   rf, ra, rb, rc, rd, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Registered, handshaked successor to the CPU's combinational ALU function set, parametrised in data width.
- Sits between the microcode sequencer (request side) and the register-file write-back (result side).
- Computes result plus N/V/Z/C flags and a per-flag valid mask.
- Optional second cycle applies 6502 BCD adjust. The 2A03 build omits it.

Parameters:
- DATA_N, 8, operand/result width; must be >= 4 and a multiple of 4.
- FUNC_N, 4, width of function select.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when both req_valid and req_ready are high.
- func  in  FUNC_N  function code: TXA=0, TXB=1, ADD=2, SUB=3, ASL=4, LSR=5, ROL=6, ROR=7, AND=8, ORA=9, EOR=10.
- a  in  DATA_N  operand A.
- b  in  DATA_N  operand B.
- cin  in  1  carry in; for SUB this is not-borrow.
- dec  in  1  decimal mode request, ADD/SUB only.
- res_valid  out  1  result register holds a result.
- res_ready  in  1  consumer takes the result when both res_valid and res_ready are high.
- result  out  DATA_N  result.
- flags  out  4  {N,V,Z,C}.
- flag_mask  out  4  {N,V,Z,C} update enables for the P register.

Behaviour:
- Reset: state IDLE. res_valid, result, flags and flag_mask are all 0. req_ready is 1 while reset is low.
- Reset mid-operation (including during ADJ) abandons the work in progress. No output appears after release.
- States:
  - IDLE: output register empty.
  - FULL: result held.
  - ADJ: decimal adjust pending.
- req_ready = (state==IDLE) | (state==FULL & res_ready). req_ready is 0 in ADJ.
- Binary operations have latency 1: a request accepted at edge k gives res_valid=1 after edge k.
- Back-to-back: in FULL, a res_ready pop and a new accept in the same cycle replace the result. res_valid stays 1, giving a throughput of 1 per cycle.
- FULL with a pop and no new accept goes to IDLE.
- Arithmetic, with msb = bit DATA_N-1:
  - ADD: {C,r} = a + b + cin. V = (a^r)&(b^r) at msb. Mask 1111.
  - SUB: same as ADD with b replaced by ~b. Mask 1111.
  - ASL: r = a<<1, C = a[msb]. Mask 1011.
  - LSR: r = a>>1, C = a[0]. Mask 1011.
  - ROL: r = {a[msb-1:0], cin}, C = a[msb]. Mask 1011.
  - ROR: r = {cin, a[msb:1]}, C = a[0]. Mask 1011.
  - AND/ORA/EOR/TXA/TXB: C = cin, V = 0. Mask 1010.
  - All operations: N = r[msb], Z = (r==0).
- Undefined func codes 11-15: result 0, flags 0, mask 0. Still handshaked with latency 1.
- dec=1 on a non-ADD/SUB function is ignored.

Optional Feature:
- Macro: ALU_DECIMAL_EN.
- Defined: an ADD/SUB with dec=1 goes IDLE/FULL to ADJ on accept, with res_valid=0. The binary result is captured.
  - The next edge applies a per-nibble adjust, rippling from the low nibble: ADD adds 6 to any nibble >9 or with a nibble carry; SUB subtracts 6 when a nibble borrowed.
  - Decimal C is the final nibble carry (ADD) or not-borrow (SUB).
  - N, V, Z come from the binary intermediate, matching NMOS 6502.
  - State goes to FULL; latency is 2.
- Not defined: dec is ignored, ADJ is unreachable and removed, and every operation has latency 1.

Decomposition:
- Shared package: alu_func_t as a 4-bit explicitly encoded enum, a flag_t struct {n,v,z,c}, and FLAG_MASK_* constants.
- ALU width derives from the shared DATA_N configuration define by default.
- Sub-module alu_comb: combinational function and flag computation, instantiated once.
- The BCD adjust stays in alu_pipe under the macro.

Test Plan:
- Reset asserted while FULL with result 0x5A -> res_valid, result, flags and mask all 0 asynchronously, before the next clock edge.
- ADD a=0x50, b=0x50, cin=0 -> result 0xA0, flags N=1 V=1 Z=0 C=0, mask 1111, one cycle after accept.
- SUB a=0x00, b=0x01, cin=1 -> 0xFF, C=0, N=1. Then ROR a=0x01, cin=1 -> 0x80, C=1, mask 1011.
- Stream of 4 ANDs with res_ready tied 1 -> res_valid high 4 consecutive cycles, req_ready never 0. Then res_ready=0 -> req_ready low, result held stable.
- ALU_DECIMAL_EN defined: ADD dec=1, a=0x19, b=0x28, cin=0 -> res_valid 2 cycles after accept, result 0x47, C=0, req_ready=0 during ADJ. Also ADD 0x99+0x01 -> 0x00, C=1.
- ALU_DECIMAL_EN not defined: ADD dec=1, 0x19+0x28 -> 0x41, latency 1. Also func=13 -> result 0, mask 0.
